// File: rtl/noc_pkg.sv
// Shared NOC types: next-hop address codes, transmitter FSM states and
// packet-length helpers used by the next-hop packet transmitter.
package noc_pkg;

    typedef logic [2:0] nhr_addr_t;

    localparam nhr_addr_t NHR_N     = 3'b000;
    localparam nhr_addr_t NHR_E     = 3'b001;
    localparam nhr_addr_t NHR_S     = 3'b010;
    localparam nhr_addr_t NHR_NONE  = 3'b011;
    localparam nhr_addr_t NHR_W     = 3'b100;
    localparam nhr_addr_t NHR_LOCAL = 3'b101;

    localparam int PKT_LEN_W = 4;

    typedef enum logic [1:0] {
        PT_IDLE,
        PT_REQ,
        PT_SEND
    } pt_state_e;

    // A header length of zero still carries the header itself, so it counts as one flit.
    function automatic logic [PKT_LEN_W-1:0] pkt_len_load(input logic [PKT_LEN_W-1:0] field);
        return (field == '0) ? PKT_LEN_W'(1) : field;
    endfunction

endpackage

// File: rtl/nhr_port_decoder.sv
// Decodes a next-hop register address into a one-hot output-port vector;
// NONE and the unused codes decode to all zeros.
module nhr_port_decoder
    import noc_pkg::*;
#(
    parameter int NUM_OUT = 5
) (
    input  logic [2:0]         addr_i,
    output logic [NUM_OUT-1:0] onehot_o
);

    always_comb begin
        // NOTE: default every combinational output first so no path infers a latch.
        onehot_o = '0;
        case (addr_i)
            NHR_N:     onehot_o[0] = 1'b1;
            NHR_E:     onehot_o[1] = 1'b1;
            NHR_S:     onehot_o[2] = 1'b1;
            NHR_W:     onehot_o[3] = 1'b1;
            NHR_LOCAL: onehot_o[4] = 1'b1;
            default:   onehot_o    = '0;
        endcase
    end

endmodule

// File: rtl/nexthop_packet_transmitter.sv
// Requests the output named by the next-hop register and streams one packet to it.
// Optional packet/flit statistics counters are built when PT_STATS_EN is defined.
module nexthop_packet_transmitter
    import noc_pkg::*;
#(
    parameter int FLIT_WIDTH = 32,
    parameter int LEN_LSB    = 0,
    parameter int NUM_OUT    = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            nhr_address_i,
    input  logic                  ib_empty_i,
    input  logic [FLIT_WIDTH-1:0] ib_data_i,
    output logic                  ib_read_o,
    output logic [NUM_OUT-1:0]    req_o,
    input  logic [NUM_OUT-1:0]    grant_i,
    output logic                  out_valid_o,
    output logic [FLIT_WIDTH-1:0] out_data_o,
    input  logic                  out_ready_i,
    output logic                  pt_almost_done_o,
    output logic                  pt_busy_o
`ifdef PT_STATS_EN
    ,
    output logic [15:0]           pkt_count_o,
    output logic [15:0]           flit_count_o
`endif
);

    pt_state_e              state_q, state_d;
    logic [NUM_OUT-1:0]     port_q, port_d;
    logic [PKT_LEN_W-1:0]   remaining_q, remaining_d;
    logic [NUM_OUT-1:0]     addr_onehot;
    logic                   grant_hit;
    logic                   xfer;

    nhr_port_decoder #(
        .NUM_OUT (NUM_OUT)
    ) u_decoder (
        .addr_i   (nhr_address_i),
        .onehot_o (addr_onehot)
    );

    assign grant_hit  = |(grant_i & port_q);
    assign out_data_o = ib_data_i;
    assign pt_busy_o  = (state_q != PT_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= PT_IDLE;
            port_q      <= '0;
            remaining_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q     <= state_d;
            port_q      <= port_d;
            remaining_q <= remaining_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        port_d           = port_q;
        remaining_d      = remaining_q;
        req_o            = '0;
        out_valid_o      = 1'b0;
        ib_read_o        = 1'b0;
        pt_almost_done_o = 1'b0;
        xfer             = 1'b0;

        case (state_q)
            PT_IDLE: begin
                if ((|addr_onehot) && !ib_empty_i) begin
                    state_d     = PT_REQ;
                    port_d      = addr_onehot;
                    remaining_d = pkt_len_load(ib_data_i[LEN_LSB +: PKT_LEN_W]);
                end
            end
            PT_REQ: begin
                req_o = port_q;
                if (grant_hit) begin
                    state_d = PT_SEND;
                end
            end
            PT_SEND: begin
                // Request stays up for the whole packet so the arbiter keeps the wormhole locked.
                req_o       = port_q;
                out_valid_o = !ib_empty_i && grant_hit;
                xfer        = out_valid_o && out_ready_i;
                ib_read_o   = xfer;
                if (xfer) begin
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == PKT_LEN_W'(1)) begin
                        pt_almost_done_o = 1'b1;
                        state_d          = PT_IDLE;
                    end
                end
            end
            default: begin
                state_d = PT_IDLE;
            end
        endcase
    end

`ifdef PT_STATS_EN
    logic [15:0] pkt_count_q;
    logic [15:0] flit_count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkt_count_q  <= '0;
            flit_count_q <= '0;
        end else begin
            if (pt_almost_done_o && (pkt_count_q != 16'hFFFF)) begin
                pkt_count_q <= pkt_count_q + 16'd1;
            end
            if (xfer && (flit_count_q != 16'hFFFF)) begin
                flit_count_q <= flit_count_q + 16'd1;
            end
        end
    end

    assign pkt_count_o  = pkt_count_q;
    assign flit_count_o = flit_count_q;
`endif

endmodule
